instr_fetch: RTL and testbench
==============================

# instr_fetch

Multi-cycle instruction fetch stage of the IITB-CPU.
- Holds the program counter and reads a binary instruction word from a synchronous instruction memory.
- Expands the 5-bit binary opcode into the 27-bit `{x, y, one-hot}` opcode vector consumed by the control decoder.
- Applies the decoder's `pc_we` / `pc_mux` decision to select the next PC.
- Sits directly upstream of the control decoder; `opcode` feeds it, and `pc_we` / `pc_mux` return from it.

## Interface
Parameters:
- `PC_W`, default 8: PC and instruction-memory address width.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset is synchronous and active-low.
- `imem_addr`: output, `PC_W` bits. Instruction-memory read address; always equals `pc`.
- `imem_rdata`: input, 32 bits. Memory word, valid the cycle after the edge that sampled `imem_addr`.
- `stall`: input, 1 bit. Holds the EXEC state (datapath/memory back-pressure).
- `pc_we`: input, 1 bit. PC advance enable from the control decoder.
- `pc_mux`: input, 1 bit. 1 selects `branch_target`; 0 selects `pc+1`.
- `branch_target`: input, `PC_W` bits. Jump/branch destination from the datapath.
- `opcode`: output, 27 bits. `{x[1:0], y[1:0], op[22:0]}` to the control decoder.
- `imm`: output, 16 bits. Immediate field of the current instruction.
- `pc_out`: output, `PC_W` bits. PC of the instruction currently presented.
- `instr_valid`: output, 1 bit. High in EXEC; `opcode` / `imm` are meaningful.
- `halted`: output, 1 bit. High in HALT.
- `illegal`: output, 1 bit. Sticky; set when an undefined opcode is fetched.

## Operation
- Word format:
  - `[31:27]` opc
  - `[26:25]` x
  - `[24:23]` y
  - `[22:16]` reserved (ignored)
  - `[15:0]` imm
- Registers: `pc`, `ir` (32 bits), `state`, `illegal`.
- States:
  - FETCH: `imem_addr = pc`; next state DECODE.
  - DECODE: `ir <= imem_rdata`. Next state is HALT if opc = 31, else EXEC.
  - EXEC: `instr_valid = 1`. Behaviour depends on `stall` and `pc_we`:
    - `stall = 1`: hold everything.
    - `stall = 0` and `pc_we = 1`: update `pc` and go to FETCH. `pc <= pc_mux ? branch_target : pc + 1`.
    - `stall = 0` and `pc_we = 0`: `pc` unchanged; go to FETCH (same instruction is re-fetched).
  - HALT: terminal until `rst_n = 0`; `imem_addr` holds `pc`.
- Opcode expansion (combinational from `ir`):
  - `opcode[26:25] = x`, `opcode[24:23] = y`.
  - opc 0 (NOOP): `op = 0`.
  - opc k, 1..22: `op[k-1] = 1`, all other `op` bits 0. `op[22]` is never set.
  - opc 23..30: `op = 0` (executes as NOOP); `illegal` set in the DECODE→EXEC edge.
  - opc 31: HALT; never presented as an instruction.
- `opcode`, `imm` and `pc_out` are driven to 0 unless in EXEC.
- `pc + 1` wraps modulo 2^`PC_W`. `branch_target` is used as-is.

## Timing
- Reset (`rst_n = 0` at an edge) values: `pc = 0`, `ir = 0`, state FETCH, `illegal = 0`.
- Outputs after reset:
  - `instr_valid = 0`, `halted = 0`.
  - `opcode = 0`, `imm = 0`, `pc_out = 0`, `imem_addr = 0`.
- Reset takes priority in every state, including mid-EXEC with `stall = 1` and HALT.
- Throughput: 3 cycles per instruction with no stall (FETCH, DECODE, EXEC). Each stall cycle adds 1.
- First `instr_valid` occurs in the 3rd cycle after reset release.
- `pc_we`, `pc_mux` and `branch_target` are sampled only at the edge ending an unstalled EXEC cycle. They are ignored in other states.
- `stall` is ignored outside EXEC.
- `halted` rises in the cycle after DECODE of opc 31.

## Test plan
- Reset/sequential run: mem[0..2] = ADD(opc 7, x=1, y=2), NOOP, SUB(opc 9), with `pc_we = 1`, `pc_mux = 0`.
  - `instr_valid` pulses in cycles 3, 6, 9.
  - `opcode` = `{2'b01, 2'b10, op[6]=1}`, then 0, then `op[8]=1`.
  - `pc_out` = 0, 1, 2.
- Taken branch: in EXEC at `pc = 4`, drive `pc_mux = 1`, `branch_target = 8'h40`.
  - Next FETCH shows `imem_addr = 0x40`.
  - Next `pc_out = 0x40`.
- Stall: hold `stall = 1` for 4 EXEC cycles.
  - `instr_valid`, `opcode`, `imm` and `pc` are constant throughout.
  - `pc` advances once only, after `stall` falls.
- `pc_we = 0`: PC stays 5 and the same word is re-fetched; `pc_out` = 5 twice.
- Wrap and illegal:
  - At `pc = 255` with `pc + 1` selected: next `imem_addr = 0`.
  - opc 25: `op = 0`, `illegal = 1`, and it stays 1 for subsequent instructions.
- Halt: opc 31 at `pc = 3`.
  - `halted = 1` and `instr_valid = 0` permanently, `imem_addr = 3`.
  - `rst_n = 0` for one edge restores all reset values.

Source files
------------

// File: rtl/instr_fetch.sv
// Multi-cycle fetch stage: PC, instruction register and opcode expansion for the control decoder.
// Three cycles per instruction (FETCH, DECODE, EXEC). A stall holds EXEC and everything it presents.
module instr_fetch #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            pc_we,
    input  logic            pc_mux,
    input  logic [PC_W-1:0] branch_target,
    output logic [26:0]     opcode,
    output logic [15:0]     imm,
    output logic [PC_W-1:0] pc_out,
    output logic            instr_valid,
    output logic            halted,
    output logic            illegal
);

    typedef struct packed {
        logic [4:0]  opc;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [6:0]  rsvd;
        logic [15:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_t;

    localparam logic [4:0]      OPC_HALT      = 5'd31;
    localparam logic [4:0]      OPC_FIRST_BAD = 5'd23;
    localparam logic [PC_W-1:0] PC_ONE        = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [PC_W-1:0] pc;
    instr_t          ir;
    instr_t          rd;
    logic [22:0]     op;
    logic            unused_rsvd;

    assign rd          = imem_rdata;
    assign imem_addr   = pc;
    assign unused_rsvd = ^ir.rsvd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= '0;
            ir          <= '0;
            illegal     <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    ir <= rd;
                    if (rd.opc == OPC_HALT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state       <= EXEC;
                        instr_valid <= 1'b1;
                        // Undefined opcodes still run as NOOP; the flag only records that one was seen.
                        if (rd.opc >= OPC_FIRST_BAD) begin
                            illegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        if (pc_we) begin
                            pc <= pc_mux ? branch_target : pc + PC_ONE;
                        end
                        state       <= FETCH;
                        instr_valid <= 1'b0;
                    end
                end
                HALT: state <= HALT;
            endcase
        end
    end

    // opc k in 1..22 lights op[k-1]; everything else decodes to all-zero.
    always_comb begin
        op = '0;
        for (int k = 1; k <= 22; k++) begin
            if (ir.opc == 5'(k)) begin
                op[k-1] = 1'b1;
            end
        end
    end

    assign opcode = instr_valid ? {ir.x, ir.y, op} : 27'd0;
    assign imm    = instr_valid ? ir.imm : 16'd0;
    assign pc_out = instr_valid ? pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: instruction-level model feeds expectations, a monitor checks presentations.
module tb_instr_fetch;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            stall = 1'b0;
    logic            pc_we = 1'b0;
    logic            pc_mux = 1'b0;
    logic [PC_W-1:0] branch_target = '0;
    logic [26:0]     opcode;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc_out;
    logic            instr_valid;
    logic            halted;
    logic            illegal;

    instr_fetch #(.PC_W(PC_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .pc_we         (pc_we),
        .pc_mux        (pc_mux),
        .branch_target (branch_target),
        .opcode        (opcode),
        .imm           (imm),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    typedef struct {
        bit          is_halt;
        logic [7:0]  pc;
        logic [26:0] opcode;
        logic [15:0] imm;
        bit          ill;
        int          len;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= rst_n;

    int   low_cnt = 0;
    int   hi_cnt = 0;
    bit   in_exec = 1'b0;
    bit   in_halt = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_exec = 1'b0;
            in_halt = 1'b0;
            low_cnt = 0;
            if (!rst_q) begin
                chk("rst_valid",   32'(instr_valid), 0);
                chk("rst_halted",  32'(halted), 0);
                chk("rst_illegal", 32'(illegal), 0);
                chk("rst_opcode",  32'(opcode), 0);
                chk("rst_imm",     32'(imm), 0);
                chk("rst_pc_out",  32'(pc_out), 0);
                chk("rst_addr",    32'(imem_addr), 0);
            end
        end else if (halted) begin
            if (!in_halt) begin
                in_halt = 1'b1;
                chk("halt_sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    chk("halt_expected", 32'(cur.is_halt), 1);
                    chk("halt_gap", low_cnt, 2);
                end
            end
            chk("halt_valid",  32'(instr_valid), 0);
            chk("halt_addr",   32'(imem_addr), 32'(cur.pc));
            chk("halt_opcode", 32'(opcode), 0);
        end else if (instr_valid) begin
            if (!in_exec) begin
                in_exec = 1'b1;
                hi_cnt  = 0;
                chk("exec_sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    chk("exec_is_instr", 32'(cur.is_halt), 0);
                    chk("exec_gap", low_cnt, 2);
                end
            end
            hi_cnt++;
            chk("pc_out",  32'(pc_out), 32'(cur.pc));
            chk("addr",    32'(imem_addr), 32'(cur.pc));
            chk("opcode",  32'(opcode), 32'(cur.opcode));
            chk("imm",     32'(imm), 32'(cur.imm));
            chk("illegal", 32'(illegal), 32'(cur.ill));
        end else begin
            if (in_exec) begin
                chk("exec_len", hi_cnt, cur.len);
                in_exec = 1'b0;
                low_cnt = 0;
            end
            low_cnt++;
            chk("idle_opcode", 32'(opcode), 0);
            chk("idle_imm",    32'(imm), 0);
            chk("idle_pc_out", 32'(pc_out), 0);
        end
    end

    // ---------------- reference model and driver ----------------
    logic [7:0] m_pc = '0;
    bit         m_ill = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        stall         = 1'($urandom_range(0, 1));
        pc_we         = 1'($urandom_range(0, 1));
        pc_mux        = 1'($urandom_range(0, 1));
        branch_target = 8'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        stall  = 1'b0;
        pc_we  = 1'b0;
        pc_mux = 1'b0;
        m_pc   = '0;
        m_ill  = 1'b0;
        rst_n  = 1'b1;
    endtask

    // Called just after the edge that enters FETCH; returns just after the edge that leaves EXEC.
    task automatic run_instr(input int s, input bit we, input bit mux, input logic [7:0] bt, input bit abort);
        exp_t        e;
        logic [31:0] w;
        logic [4:0]  opc;
        w         = mem[m_pc];
        opc       = w[31:27];
        e.pc      = m_pc;
        e.is_halt = (opc == 5'd31);
        e.len     = s + 1;
        e.imm     = w[15:0];
        e.opcode  = '0;
        e.ill     = 1'b0;
        if (!e.is_halt) begin
            if (opc >= 5'd23) m_ill = 1'b1;
            e.ill    = m_ill;
            e.opcode = {w[26:23], (opc >= 5'd1 && opc <= 5'd22) ? (23'd1 << (opc - 5'd1)) : 23'd0};
        end
        q.push_back(e);
        junk();
        cyc();
        junk();
        cyc();
        if (e.is_halt) begin
            for (int i = 0; i < 4; i++) begin
                junk();
                cyc();
            end
            return;
        end
        for (int i = 0; i < s; i++) begin
            junk();
            stall = 1'b1;
            cyc();
        end
        if (abort) return;
        stall         = 1'b0;
        pc_we         = we;
        pc_mux        = mux;
        branch_target = bt;
        cyc();
        if (we) m_pc = mux ? bt : m_pc + 8'd1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;

        // Sequential run: ADD, NOOP, SUB.
        mem[0] = {5'd7, 2'd1, 2'd2, 7'd0, 16'h1234};
        mem[1] = 32'd0;
        mem[2] = {5'd9, 2'd3, 2'd0, 7'h7f, 16'hbeef};
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc();
        chk("drain_seq", q.size(), 0);

        // Branch, stall, pc_we=0 refetch, wrap, illegal, halt.
        for (int a = 0; a < 256; a++) mem[a] = {5'($urandom_range(1, 22)), 27'($urandom)};
        mem[255] = {5'd25, 2'd2, 2'd1, 7'd0, 16'h5a5a};
        mem[3]   = {5'd31, 27'd0};
        do_reset();
        run_instr(0, 1'b1, 1'b1, 8'h04, 1'b0);
        run_instr(0, 1'b1, 1'b1, 8'h40, 1'b0);
        run_instr(4, 1'b1, 1'b1, 8'h05, 1'b0);
        run_instr(0, 1'b0, 1'b1, 8'h99, 1'b0);
        run_instr(1, 1'b1, 1'b1, 8'hff, 1'b0);
        run_instr(0, 1'b1, 1'b0, 8'h33, 1'b0);
        run_instr(2, 1'b1, 1'b1, 8'h03, 1'b0);
        run_instr(0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("drain_dir", q.size(), 0);
        chk("model_wrap_pc", 32'(m_pc), 32'h3);

        // Reset while stalled in EXEC.
        do_reset();
        run_instr(0, 1'b1, 1'b0, 8'h00, 1'b0);
        run_instr(3, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("drain_abort", q.size(), 0);

        for (int seg = 0; seg < 30; seg++) begin
            bit done;
            for (int a = 0; a < 256; a++) begin
                logic [4:0] o;
                o = 5'($urandom_range(0, 30));
                if ($urandom_range(0, 40) == 0) o = 5'd31;
                mem[a] = {o, 27'($urandom)};
            end
            do_reset();
            done = 1'b0;
            for (int n = 0; n < 20 && !done; n++) begin
                bit ab;
                bit hlt;
                int s;
                hlt = (mem[m_pc][31:27] == 5'd31);
                s   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                ab  = (n == 19) && (s > 0) && (seg % 2 == 1);
                run_instr(s, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), ab);
                done = hlt || ab;
            end
            if (!done) cyc();
            chk("drain_rand", q.size(), 0);
        end

        rst_n = 1'b0;
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
